// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - operand issue and writeback stage feeding the ALU
module alu_issue_stage #(
    parameter int NREG = 16,
    parameter int RW   = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_opcode,
    input  logic [RW-1:0] in_rd,
    input  logic [RW-1:0] in_ra,
    input  logic [RW-1:0] in_rb,
    input  logic          in_imm_sel,
    input  logic [31:0]   in_imm,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [4:0]    alu_opcode,
    input  logic [31:0]   alu_out,
    input  logic          alu_flag,
    output logic          wb_valid,
    output logic [RW-1:0] wb_rd,
    output logic [31:0]   wb_data,
    output logic          wb_illegal,
    output logic          flag_z,
    output logic          flag_n,
    output logic          flag_c,
    input  logic [RW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);

    // Opcode held on the ALU outside EXEC so every op presents a fresh opcode change.
    localparam logic [4:0] OP_NEUTRAL = 5'b10000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_OPER,
        S_EXEC,
        S_WB
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [31:0]   r_regs [NREG];
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [4:0]    r_opcode;
    logic [4:0]    r_alu_opcode;
    logic [RW-1:0] r_rd;
    logic          r_illegal;
    logic [31:0]   r_wb_data;
    logic          r_z;
    logic          r_n;
    logic          r_c;
    logic          w_accept;
    logic [31:0]   w_ra_val;
    logic [31:0]   w_rb_val;

    // Opcodes 00010, 00111 and 01010-01111 are undefined; every 1xxxx opcode is legal.
    function automatic logic f_legal(input logic [4:0] op);
        logic ok;
        ok = 1'b1;
        if (!op[4]) begin
            case (op[3:0])
                4'b0010, 4'b0111, 4'b1010, 4'b1011,
                4'b1100, 4'b1101, 4'b1110, 4'b1111: ok = 1'b0;
                default:                            ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

    assign w_ra_val = (in_ra == '0)    ? 32'd0 : r_regs[in_ra];
    assign w_rb_val = (in_rb == '0)    ? 32'd0 : r_regs[in_rb];
    assign dbg_data = (dbg_addr == '0) ? 32'd0 : r_regs[dbg_addr];
    assign w_accept = (r_state == S_IDLE) && in_valid;

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_opcode = r_alu_opcode;
    assign wb_rd      = r_rd;
    assign wb_data    = r_wb_data;
    assign flag_z     = r_z;
    assign flag_n     = r_n;
    assign flag_c     = r_c;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state and handshake/writeback strobes; strictly one op in flight.
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        wb_valid   = 1'b0;
        wb_illegal = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = S_OPER;
            end
            S_OPER: w_next = S_EXEC;
            S_EXEC: w_next = S_WB;
            S_WB: begin
                wb_valid   = 1'b1;
                wb_illegal = r_illegal;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand capture, ALU opcode sequencing, result writeback and flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= 32'd0;
            r_a          <= 32'd0;
            r_b          <= 32'd0;
            r_opcode     <= OP_NEUTRAL;
            r_alu_opcode <= OP_NEUTRAL;
            r_rd         <= '0;
            r_illegal    <= 1'b0;
            r_wb_data    <= 32'd0;
            r_z          <= 1'b0;
            r_n          <= 1'b0;
            r_c          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a       <= w_ra_val;
                r_b       <= in_imm_sel ? in_imm : w_rb_val;
                r_opcode  <= in_opcode;
                r_rd      <= in_rd;
                r_illegal <= !f_legal(in_opcode);
            end
            if (r_state == S_OPER) r_alu_opcode <= r_opcode;
            if (r_state == S_EXEC) begin
                r_alu_opcode <= OP_NEUTRAL;
                if (!r_illegal) begin
                    if (r_rd != '0) r_regs[r_rd] <= alu_out;
                    r_wb_data <= alu_out;
                    r_z       <= (alu_out == 32'd0);
                    r_n       <= alu_out[31];
                    r_c       <= alu_flag;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_opcode;
    logic [3:0]  in_rd, in_ra, in_rb;
    logic        in_imm_sel;
    logic [31:0] in_imm;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_out;
    logic        alu_flag;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_illegal;
    logic        flag_z, flag_n, flag_c;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    always #5 clock = ~clock;

    alu_issue_stage #(.NREG(16), .RW(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_rd(in_rd), .in_ra(in_ra), .in_rb(in_rb),
        .in_imm_sel(in_imm_sel), .in_imm(in_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_illegal(wb_illegal),
        .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    typedef struct {
        logic [3:0]  rd;
        logic [31:0] data;
        logic        ill;
    } wb_t;

    wb_t         sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_regs [16];
    logic        m_z, m_n, m_c;
    logic [31:0] m_wb_data;

    // ALU stand-in: {flag, result}
    function automatic logic [32:0] alu_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] r;
        case (op)
            5'b00000: r = {1'b0, a} + {1'b0, b};
            5'b00101: r = {(a < b), a - b};
            5'b10010: r = {1'b0, a};
            5'b10011: r = {1'b0, b};
            5'b10000: r = 33'd0;
            default:  r = {1'b1, a ^ b};
        endcase
        return r;
    endfunction

    always_comb {alu_flag, alu_out} = alu_model(alu_opcode, alu_a, alu_b);

    function automatic logic legal(input logic [4:0] op);
        return op[4] || (op inside {5'b00000, 5'b00001, 5'b00011, 5'b00100,
                                    5'b00101, 5'b00110, 5'b01000, 5'b01001});
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
        m_z = 1'b0; m_n = 1'b0; m_c = 1'b0; m_wb_data = 32'd0;
        sb.delete();
    endtask

    task automatic model_push(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                              input logic [3:0] rb, input logic sel, input logic [31:0] imm);
        logic [31:0] a, b;
        logic [32:0] r;
        wb_t e;
        a = (ra == 4'd0) ? 32'd0 : m_regs[ra];
        b = sel ? imm : ((rb == 4'd0) ? 32'd0 : m_regs[rb]);
        r = alu_model(op, a, b);
        if (legal(op)) begin
            if (rd != 4'd0) m_regs[rd] = r[31:0];
            m_wb_data = r[31:0];
            m_z = (r[31:0] == 32'd0);
            m_n = r[31];
            m_c = r[32];
        end
        e.rd = rd; e.data = m_wb_data; e.ill = !legal(op);
        sb.push_back(e);
    endtask

    // Advance to the next falling edge and retire any writeback against the scoreboard.
    task automatic tick();
        wb_t e;
        @(negedge clock);
        if (wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_data", wb_data, e.data);
                chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                chk("wb_illegal", 32'(wb_illegal), 32'(e.ill));
            end
        end
    endtask

    task automatic drive(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                         input logic [3:0] rb, input logic sel, input logic [31:0] imm);
        in_opcode = op; in_rd = rd; in_ra = ra; in_rb = rb; in_imm_sel = sel; in_imm = imm;
        in_valid = 1'b1;
    endtask

    // Offer an op and return at the falling edge just after the accepting edge.
    task automatic issue(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                         input logic [3:0] rb, input logic sel, input logic [31:0] imm, input logic hold);
        int waits;
        model_push(op, rd, ra, rb, sel, imm);
        drive(op, rd, ra, rb, sel, imm);
        waits = 0;
        while (in_ready !== 1'b1 && waits < 8) begin
            tick();
            waits++;
        end
        if (in_ready !== 1'b1) chk("accept_timeout", 32'(in_ready), 32'd1);
        tick();
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic dbg_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    task automatic run_op(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] ra,
                          input logic [3:0] rb, input logic sel, input logic [31:0] imm);
        issue(op, rd, ra, rb, sel, imm, 1'b0);
        chk("oper_opcode", 32'(alu_opcode), 32'h10);
        chk("oper_ready", 32'(in_ready), 32'd0);
        tick();
        chk("exec_opcode", 32'(alu_opcode), 32'(op));
        chk("exec_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        chk("wb_latency", 32'(wb_valid), 32'd1);
        chk("wb_opcode", 32'(alu_opcode), 32'h10);
        chk("flag_z", 32'(flag_z), 32'(m_z));
        chk("flag_n", 32'(flag_n), 32'(m_n));
        chk("flag_c", 32'(flag_c), 32'(m_c));
        dbg_chk("dbg_rd", rd, (rd == 4'd0) ? 32'd0 : m_regs[rd]);
        tick();
        chk("idle_ready", 32'(in_ready), 32'd1);
        chk("idle_wb_valid", 32'(wb_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_opcode = 5'd0; in_rd = 4'd0; in_ra = 4'd0;
        in_rb = 4'd0; in_imm_sel = 1'b0; in_imm = 32'd0; dbg_addr = 4'd0;
        model_clear();
        repeat (2) @(negedge clock);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_opcode", 32'(alu_opcode), 32'h10);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        reset = 1'b0;
        tick();

        run_op(5'b10011, 4'd1, 4'd0, 4'd0, 1'b1, 32'h0000_0005);
        run_op(5'b00000, 4'd2, 4'd1, 4'd0, 1'b1, 32'hFFFF_FFFB);
        run_op(5'b00101, 4'd3, 4'd0, 4'd0, 1'b1, 32'h0000_0001);
        run_op(5'b10010, 4'd0, 4'd0, 4'd0, 1'b1, 32'hDEAD_BEEF);
        dbg_chk("r0_zero", 4'd0, 32'd0);

        // back-to-back adds with in_valid held high
        issue(5'b00000, 4'd4, 4'd1, 4'd0, 1'b1, 32'd2, 1'b1);
        model_push(5'b00000, 4'd5, 4'd1, 4'd0, 1'b1, 32'd7);
        drive(5'b00000, 4'd5, 4'd1, 4'd0, 1'b1, 32'd7);
        chk("b2b_oper_opcode", 32'(alu_opcode), 32'h10);
        chk("b2b_busy0", 32'(in_ready), 32'd0);
        tick();
        chk("b2b_busy1", 32'(in_ready), 32'd0);
        tick();
        chk("b2b_busy2", 32'(in_ready), 32'd0);
        chk("b2b_wb_opcode", 32'(alu_opcode), 32'h10);
        chk("b2b_wb_valid", 32'(wb_valid), 32'd1);
        tick();
        chk("b2b_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_oper_opcode2", 32'(alu_opcode), 32'h10);
        tick();
        tick();
        chk("b2b_wb_opcode2", 32'(alu_opcode), 32'h10);
        chk("b2b_wb_valid2", 32'(wb_valid), 32'd1);
        tick();
        dbg_chk("r4", 4'd4, 32'd7);
        dbg_chk("r5", 4'd5, 32'd12);
        chk("b2b_drained", 32'(sb.size()), 32'd0);

        run_op(5'b00000, 4'd8, 4'd4, 4'd5, 1'b0, 32'hFFFF_0000);
        run_op(5'b00000, 4'd0, 4'd0, 4'd0, 1'b1, 32'd0);
        run_op(5'b00010, 4'd6, 4'd1, 4'd0, 1'b1, 32'h0000_1234);
        dbg_chk("r6_untouched", 4'd6, 32'd0);
        chk("illegal_keeps_z", 32'(flag_z), 32'd1);

        // reset in the middle of EXEC
        drive(5'b00000, 4'd7, 4'd1, 4'd0, 1'b1, 32'd3);
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_exec_opcode", 32'(alu_opcode), 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_clear();
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        chk("mid_rst_opcode", 32'(alu_opcode), 32'h10);
        chk("mid_rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_wb_data", wb_data, 32'd0);
        chk("mid_rst_flags", {29'd0, flag_z, flag_n, flag_c}, 32'd0);
        dbg_chk("mid_rst_r7", 4'd7, 32'd0);
        dbg_chk("mid_rst_r1", 4'd1, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_no_wb", 32'(wb_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
